// File: rtl/mos6502_intc.sv
// ---------------------------------------------------------------------------
// mos6502_intc
//
// Vectored interrupt controller for the mos6502 core. It turns NUM_IRQ
// prioritised, maskable interrupt channels (level or edge per channel) into
// the core's single active-low IRQ line, adds one edge-triggered NMI source,
// and watches the CPU address bus so that, when an IRQ is being serviced, the
// $FFFE/$FFFF vector fetch returns a per-channel 16-bit vector instead of
// the memory contents.
//
// Ports
//   clk        CPU clock, all logic on the rising edge
//   reset      asynchronous, active-low reset
//   irq_src    interrupt sources (active high, synchronous to clk)
//   nmi_src    NMI source (active high, rising-edge sensitive)
//   cpu_addr   core address bus
//   cpu_we_n   core write enable (0 = write)
//   rdy        core ready; 0 freezes all CPU-side sequencing
//   irq_out    active-low IRQ to the core (registered)
//   nmi_out    active-low NMI to the core
//   vec_sel    1 = core d_in mux takes vec_data instead of memory
//   vec_data   substituted vector byte
//   cfg_cs     config access strobe
//   cfg_we     config write qualifier
//   cfg_addr   config register address
//   cfg_wdata  config write data
//   cfg_rdata  config read data (registered, valid the cycle after a read)
//
// Register map (bits above NUM_IRQ read 0 and ignore writes)
//   0x00 ENABLE   rw
//   0x01 PENDING  read; writing 1 clears edge-mode bits
//   0x02 EDGE_SEL rw, 1 = edge mode
//   0x03 ACTIVE   ro, bit7 valid, bits2:0 last acknowledged channel
//   0x10+2*ch / 0x11+2*ch  vector lo / hi byte of channel ch
// ---------------------------------------------------------------------------
module mos6502_intc #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [15:0] VEC_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               nmi_src,
    input  logic [15:0]        cpu_addr,
    input  logic               cpu_we_n,
    input  logic               rdy,
    output logic               irq_out,
    output logic               nmi_out,
    output logic               vec_sel,
    output logic [7:0]         vec_data,
    input  logic               cfg_cs,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata
);

    localparam logic [4:0]  ADDR_ENABLE   = 5'h00;
    localparam logic [4:0]  ADDR_PENDING  = 5'h01;
    localparam logic [4:0]  ADDR_EDGE_SEL = 5'h02;
    localparam logic [4:0]  ADDR_ACTIVE   = 5'h03;

    localparam logic [15:0] IRQ_VEC_LO    = 16'hFFFE;
    localparam logic [15:0] IRQ_VEC_HI    = 16'hFFFF;
    localparam logic [15:0] NMI_VEC_LO    = 16'hFFFA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEC_LO = 2'd1,
        ST_VEC_HI = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_IRQ-1:0] enable_reg;
    logic [NUM_IRQ-1:0] edge_sel_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] src_prev_reg;
    logic               active_valid_reg;
    logic [2:0]         active_ch_reg;
    logic               nmi_pend_reg;
    logic               nmi_prev_reg;
    logic               irq_out_reg;
    logic [7:0]         cfg_rdata_reg;

    logic [7:0]         vec_lo_reg [NUM_IRQ];
    logic [7:0]         vec_hi_reg [NUM_IRQ];

    state_t             state_reg;
    state_t             state_next;
    logic [2:0]         win_reg;
    logic [2:0]         win_next;
    logic               vec_sel_reg;
    logic               vec_sel_next;
    logic [7:0]         vec_data_reg;
    logic [7:0]         vec_data_next;

    // -----------------------------------------------------------------------
    // Common decode
    // -----------------------------------------------------------------------
    logic               qual_rd;
    logic               cfg_wr;
    logic               cfg_rd;
    logic               ack_fire;
    logic [NUM_IRQ-1:0] req;
    logic [2:0]         req_win;
    logic [7:0]         req_vec_lo;
    logic [7:0]         win_vec_hi;
    logic [7:0]         rd_data;
    logic [NUM_IRQ-1:0] vec_wr_lo;
    logic [NUM_IRQ-1:0] vec_wr_hi;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic               nmi_set;
    logic               nmi_clr;

    assign qual_rd = rdy & cpu_we_n;
    assign cfg_wr  = cfg_cs & cfg_we;
    assign cfg_rd  = cfg_cs & ~cfg_we;
    assign req     = pending_reg & enable_reg;

    // -----------------------------------------------------------------------
    // Per-channel pending logic and vector write decode
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            assign edge_set[gi]  = irq_src[gi] & ~src_prev_reg[gi];
            assign w1c_clr[gi]   = cfg_wr && (cfg_addr == ADDR_PENDING) && cfg_wdata[gi];
            assign ack_clr[gi]   = ack_fire && (win_reg == 3'(gi));
            // A fresh source edge wins over both clear paths, so an edge
            // that lands in the clearing cycle is never lost.
            assign pending_next[gi] = edge_sel_reg[gi]
                                    ? (edge_set[gi] | (pending_reg[gi] & ~(w1c_clr[gi] | ack_clr[gi])))
                                    : irq_src[gi];
            assign vec_wr_lo[gi] = cfg_wr && cfg_addr[4] && (cfg_addr[3:1] == 3'(gi)) && !cfg_addr[0];
            assign vec_wr_hi[gi] = cfg_wr && cfg_addr[4] && (cfg_addr[3:1] == 3'(gi)) &&  cfg_addr[0];
        end
    endgenerate

    // Lowest set index wins (channel 0 is highest priority).
    always_comb begin
        req_win = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_win = 3'(i);
            end
        end
    end

    // Vector byte selection: lo byte follows the channel being captured,
    // hi byte follows the channel latched at the $FFFE fetch.
    always_comb begin
        req_vec_lo = 8'h00;
        win_vec_hi = 8'h00;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req_win == 3'(i)) begin
                req_vec_lo = vec_lo_reg[i];
            end
            if (win_reg == 3'(i)) begin
                win_vec_hi = vec_hi_reg[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Vector fetch FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        win_next      = win_reg;
        vec_sel_next  = vec_sel_reg;
        vec_data_next = vec_data_reg;
        ack_fire      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (qual_rd) begin
                    vec_sel_next = 1'b0;
                    // With nothing requested this is a BRK fetch: memory
                    // supplies the vector.
                    if ((cpu_addr == IRQ_VEC_LO) && (|req)) begin
                        win_next      = req_win;
                        vec_data_next = req_vec_lo;
                        vec_sel_next  = 1'b1;
                        state_next    = ST_VEC_LO;
                    end
                end
            end
            ST_VEC_LO: begin
                if (qual_rd) begin
                    if (cpu_addr == IRQ_VEC_HI) begin
                        vec_data_next = win_vec_hi;
                        vec_sel_next  = 1'b1;
                        ack_fire      = 1'b1;
                        state_next    = ST_VEC_HI;
                    end else begin
                        // Sequence broken: drop substitution, acknowledge nothing.
                        vec_sel_next = 1'b0;
                        state_next   = ST_IDLE;
                    end
                end
            end
            ST_VEC_HI: begin
                if (qual_rd) begin
                    vec_sel_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                vec_sel_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            win_reg      <= 3'd0;
            vec_sel_reg  <= 1'b0;
            vec_data_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            win_reg      <= win_next;
            vec_sel_reg  <= vec_sel_next;
            vec_data_reg <= vec_data_next;
        end
    end

    // -----------------------------------------------------------------------
    // NMI: rising-edge capture, cleared by the $FFFA fetch. The edge wins
    // over a coincident clear.
    // -----------------------------------------------------------------------
    assign nmi_set = nmi_src & ~nmi_prev_reg;
    assign nmi_clr = qual_rd && (cpu_addr == NMI_VEC_LO);

    // -----------------------------------------------------------------------
    // Config read mux
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (cfg_addr)
            ADDR_ENABLE:   rd_data[NUM_IRQ-1:0] = enable_reg;
            ADDR_PENDING:  rd_data[NUM_IRQ-1:0] = pending_reg;
            ADDR_EDGE_SEL: rd_data[NUM_IRQ-1:0] = edge_sel_reg;
            ADDR_ACTIVE:   rd_data = {active_valid_reg, 4'b0000, active_ch_reg};
            default: begin
                if (cfg_addr[4]) begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (cfg_addr[3:1] == 3'(i)) begin
                            rd_data = cfg_addr[0] ? vec_hi_reg[i] : vec_lo_reg[i];
                        end
                    end
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control / status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_reg       <= '0;
            edge_sel_reg     <= '0;
            pending_reg      <= '0;
            src_prev_reg     <= '0;
            active_valid_reg <= 1'b0;
            active_ch_reg    <= 3'd0;
            nmi_pend_reg     <= 1'b0;
            nmi_prev_reg     <= 1'b0;
            irq_out_reg      <= 1'b1;
            cfg_rdata_reg    <= 8'h00;
        end else begin
            pending_reg  <= pending_next;
            src_prev_reg <= irq_src;
            nmi_prev_reg <= nmi_src;
            irq_out_reg  <= ~|req;

            if (nmi_set) begin
                nmi_pend_reg <= 1'b1;
            end else if (nmi_clr) begin
                nmi_pend_reg <= 1'b0;
            end

            if (ack_fire) begin
                active_valid_reg <= 1'b1;
                active_ch_reg    <= win_reg;
            end

            if (cfg_wr && (cfg_addr == ADDR_ENABLE)) begin
                enable_reg <= cfg_wdata[NUM_IRQ-1:0];
            end
            if (cfg_wr && (cfg_addr == ADDR_EDGE_SEL)) begin
                edge_sel_reg <= cfg_wdata[NUM_IRQ-1:0];
            end

            if (cfg_rd) begin
                cfg_rdata_reg <= rd_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Vector registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                vec_lo_reg[i] <= VEC_RESET[7:0];
                vec_hi_reg[i] <= VEC_RESET[15:8];
            end
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (vec_wr_lo[i]) begin
                    vec_lo_reg[i] <= cfg_wdata;
                end
                if (vec_wr_hi[i]) begin
                    vec_hi_reg[i] <= cfg_wdata;
                end
            end
        end
    end

    assign irq_out   = irq_out_reg;
    assign nmi_out   = ~nmi_pend_reg;
    assign vec_sel   = vec_sel_reg;
    assign vec_data  = vec_data_reg;
    assign cfg_rdata = cfg_rdata_reg;

endmodule

// File: tb/tb_mos6502_intc.sv
// ---------------------------------------------------------------------------
// tb_mos6502_intc
//
// Directed bench for mos6502_intc: priority fetch, edge mode, BRK and aborted
// fetches, rdy stalls, NMI, clear races and reset during a vector fetch.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mos6502_intc;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_src;
    logic        nmi_src;
    logic [15:0] cpu_addr;
    logic        cpu_we_n;
    logic        rdy;
    logic        irq_out;
    logic        nmi_out;
    logic        vec_sel;
    logic [7:0]  vec_data;
    logic        cfg_cs;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd;

    mos6502_intc #(
        .NUM_IRQ   (8),
        .VEC_RESET (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .nmi_src   (nmi_src),
        .cpu_addr  (cpu_addr),
        .cpu_we_n  (cpu_we_n),
        .rdy       (rdy),
        .irq_out   (irq_out),
        .nmi_out   (nmi_out),
        .vec_sel   (vec_sel),
        .vec_data  (vec_data),
        .cfg_cs    (cfg_cs),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
        cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_cs = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [4:0] a, output logic [7:0] d);
        cfg_cs = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        tick();
        d = cfg_rdata;
        cfg_cs = 1'b0;
        $display("cfg read  addr=%h data=%h", a, d);
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        cpu_addr = a; cpu_we_n = 1'b1;
        tick();
        $display("cpu read  addr=%h vec_sel=%b vec_data=%h irq_out=%b nmi_out=%b",
                 a, vec_sel, vec_data, irq_out, nmi_out);
    endtask

    initial begin
        reset = 1'b0; irq_src = 8'h00; nmi_src = 1'b0;
        cpu_addr = 16'h0200; cpu_we_n = 1'b1; rdy = 1'b1;
        cfg_cs = 1'b0; cfg_we = 1'b0; cfg_addr = 5'h00; cfg_wdata = 8'h00;
        tick();
        tick();
        check("rst_irq_out",  {15'd0, irq_out}, 16'h0001);
        check("rst_nmi_out",  {15'd0, nmi_out}, 16'h0001);
        check("rst_vec_sel",  {15'd0, vec_sel}, 16'h0000);
        check("rst_vec_data", {8'd0, vec_data}, 16'h0000);
        check("rst_cfg_rdata",{8'd0, cfg_rdata}, 16'h0000);
        reset = 1'b1;
        tick();

        // ---- Priority: channels 3 and 5 level, channel 3 wins ----
        cfg_write(5'h00, 8'hFF);
        cfg_write(5'h16, 8'h34);
        cfg_write(5'h17, 8'h12);
        cfg_write(5'h1A, 8'h78);
        cfg_write(5'h1B, 8'h56);
        irq_src = 8'h28;
        tick();
        tick();
        check("prio_irq_low", {15'd0, irq_out}, 16'h0000);
        cfg_read(5'h01, rd);
        check("prio_pending", {8'd0, rd}, 16'h0028);
        cpu_rd(16'hFFFE);
        check("prio_lo_sel",  {15'd0, vec_sel}, 16'h0001);
        check("prio_lo_data", {8'd0, vec_data}, 16'h0034);
        cpu_rd(16'hFFFF);
        check("prio_hi_sel",  {15'd0, vec_sel}, 16'h0001);
        check("prio_hi_data", {8'd0, vec_data}, 16'h0012);
        cpu_rd(16'h0200);
        check("prio_sel_drop", {15'd0, vec_sel}, 16'h0000);
        cfg_read(5'h03, rd);
        check("prio_active",  {8'd0, rd}, 16'h0083);
        check("prio_irq_stays", {15'd0, irq_out}, 16'h0000);
        irq_src = 8'h00;
        tick();
        tick();
        check("prio_irq_release", {15'd0, irq_out}, 16'h0001);

        // ---- Edge mode on channel 2 ----
        cfg_write(5'h02, 8'h04);
        cfg_write(5'h14, 8'hCD);
        cfg_write(5'h15, 8'hAB);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        check("edge_irq_not_yet", {15'd0, irq_out}, 16'h0001);
        tick();
        check("edge_irq_low", {15'd0, irq_out}, 16'h0000);
        cfg_read(5'h01, rd);
        check("edge_pending", {8'd0, rd}, 16'h0004);
        cpu_rd(16'hFFFE);
        check("edge_lo_data", {8'd0, vec_data}, 16'h00CD);
        cpu_rd(16'hFFFF);
        check("edge_hi_data", {8'd0, vec_data}, 16'h00AB);
        cpu_rd(16'h0200);
        check("edge_irq_high", {15'd0, irq_out}, 16'h0001);
        check("edge_sel_drop", {15'd0, vec_sel}, 16'h0000);
        cfg_read(5'h01, rd);
        check("edge_pend_clr", {8'd0, rd}, 16'h0000);
        cfg_read(5'h03, rd);
        check("edge_active", {8'd0, rd}, 16'h0082);

        // ---- BRK: nothing requested ----
        cpu_rd(16'hFFFE);
        check("brk_lo_sel", {15'd0, vec_sel}, 16'h0000);
        cpu_rd(16'hFFFF);
        check("brk_hi_sel", {15'd0, vec_sel}, 16'h0000);

        // ---- Aborted fetch: $FFFE then $1000 ----
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        cpu_rd(16'hFFFE);
        check("abort_lo_sel",  {15'd0, vec_sel}, 16'h0001);
        check("abort_lo_data", {8'd0, vec_data}, 16'h00CD);
        cpu_rd(16'h1000);
        check("abort_sel_drop", {15'd0, vec_sel}, 16'h0000);
        cpu_rd(16'hFFFF);
        check("abort_idle_ffff", {15'd0, vec_sel}, 16'h0000);
        cfg_read(5'h01, rd);
        check("abort_pending", {8'd0, rd}, 16'h0004);
        cfg_read(5'h03, rd);
        check("abort_active", {8'd0, rd}, 16'h0082);
        cfg_write(5'h01, 8'h04);
        cfg_read(5'h01, rd);
        check("w1c_clear", {8'd0, rd}, 16'h0000);

        // ---- rdy stall between lo and hi fetch ----
        irq_src = 8'h08;
        tick();
        tick();
        cpu_rd(16'hFFFE);
        check("stall_lo_data", {8'd0, vec_data}, 16'h0034);
        rdy = 1'b0;
        cpu_addr = 16'h1000;
        tick();
        tick();
        tick();
        check("stall_hold_data", {8'd0, vec_data}, 16'h0034);
        check("stall_hold_sel",  {15'd0, vec_sel}, 16'h0001);
        rdy = 1'b1;
        cpu_rd(16'hFFFF);
        check("stall_hi_data", {8'd0, vec_data}, 16'h0012);
        cpu_rd(16'h0200);
        check("stall_sel_drop", {15'd0, vec_sel}, 16'h0000);
        irq_src = 8'h00;
        tick();

        // ---- NMI ----
        nmi_src = 1'b1;
        tick();
        check("nmi_low", {15'd0, nmi_out}, 16'h0000);
        tick();
        check("nmi_held", {15'd0, nmi_out}, 16'h0000);
        cpu_rd(16'hFFFA);
        check("nmi_cleared", {15'd0, nmi_out}, 16'h0001);
        check("nmi_no_subst", {15'd0, vec_sel}, 16'h0000);
        nmi_src = 1'b0;
        tick();

        // ---- Write-1-clear racing a new edge ----
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        tick();
        irq_src = 8'h04;
        cfg_write(5'h01, 8'h04);
        irq_src = 8'h00;
        cfg_read(5'h01, rd);
        check("race_w1c", {8'd0, rd}, 16'h0004);

        // ---- Reset in the middle of VEC_LO ----
        nmi_src = 1'b1;
        tick();
        nmi_src = 1'b0;
        check("pre_rst_nmi", {15'd0, nmi_out}, 16'h0000);
        tick();
        cpu_rd(16'hFFFE);
        check("pre_rst_sel", {15'd0, vec_sel}, 16'h0001);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_sel",  {15'd0, vec_sel}, 16'h0000);
        check("mid_rst_data", {8'd0, vec_data}, 16'h0000);
        check("mid_rst_irq",  {15'd0, irq_out}, 16'h0001);
        check("mid_rst_nmi",  {15'd0, nmi_out}, 16'h0001);
        tick();
        reset = 1'b1;
        tick();
        cfg_read(5'h00, rd);
        check("post_rst_enable", {8'd0, rd}, 16'h0000);
        cfg_read(5'h01, rd);
        check("post_rst_pending", {8'd0, rd}, 16'h0000);
        cfg_read(5'h02, rd);
        check("post_rst_edge_sel", {8'd0, rd}, 16'h0000);
        cfg_read(5'h03, rd);
        check("post_rst_active", {8'd0, rd}, 16'h0000);
        cfg_read(5'h16, rd);
        check("post_rst_vec3_lo", {8'd0, rd}, 16'h0000);
        cfg_read(5'h17, rd);
        check("post_rst_vec3_hi", {8'd0, rd}, 16'h0000);
        cpu_rd(16'hFFFE);
        check("post_rst_fetch", {15'd0, vec_sel}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
